// File: rtl/exc_commit.sv
// Writeback exception/interrupt commit: priority-encodes the retiring instr against registered interrupts.
// Latency 1 (registered commit pulses); wb_ready drops while idling or blanking after a redirect.
module exc_commit #(
    parameter int PC_W      = 32,
    parameter int INT_W     = 12,
    parameter int BLANK_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [PC_W-1:0]  wb_pc,
    input  logic [13:0]      wb_exc_vec,
    input  logic [PC_W-1:0]  wb_badv,
    input  logic             wb_is_ertn,
    input  logic             wb_is_idle,
    input  logic             wb_is_refetch,
    input  logic             ie,
    input  logic [INT_W-1:0] lie,
    input  logic [INT_W-1:0] is,
    output logic             is_exc,
    output logic [5:0]       excode,
    output logic [8:0]       esubcode,
    output logic [PC_W-1:0]  badvaddr,
    output logic [PC_W-1:0]  csr_pc,
    output logic             is_ertn,
    output logic             is_fetch_again,
    output logic             is_idle,
    output logic             flush
);

    localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    typedef enum logic [1:0] {S_RUN, S_IDLE, S_BLANK} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  blank_cnt;
    logic              int_pend;
    logic [PC_W-1:0]   idle_pc;

    logic [3:0]        exc_idx;
    logic              exc_any;
    logic [5:0]        exc_code;
    logic [8:0]        exc_sub;
    logic [PC_W-1:0]   exc_badv;

    logic accept, take_int, take_exc, take_ertn, take_refetch, take_idle, idle_wake, redirect;

    logic              is_exc_d, is_ertn_d, is_fetch_again_d, is_idle_d, flush_d;
    logic [5:0]        excode_d;
    logic [8:0]        esubcode_d;
    logic [PC_W-1:0]   badvaddr_d, csr_pc_d;

    // Lowest set bit wins: bit 0 is the highest-priority source.
    assign exc_any = |wb_exc_vec;
    always_comb begin
        exc_idx = 4'd0;
        for (int i = 13; i >= 0; i--) begin
            if (wb_exc_vec[i]) exc_idx = 4'(i);
        end
    end

    always_comb begin
        exc_code = 6'h00;
        exc_sub  = 9'd0;
        exc_badv = '0;
        case (exc_idx)
            4'd0:  begin exc_code = 6'h08; exc_badv = wb_pc;   end
            4'd1:  begin exc_code = 6'h3F; exc_badv = wb_pc;   end
            4'd2:  begin exc_code = 6'h03; exc_badv = wb_pc;   end
            4'd3:  begin exc_code = 6'h07; exc_badv = wb_pc;   end
            4'd4:  exc_code = 6'h0B;
            4'd5:  exc_code = 6'h0C;
            4'd6:  exc_code = 6'h0D;
            4'd7:  exc_code = 6'h0E;
            4'd8:  begin exc_code = 6'h09; exc_badv = wb_badv; end
            4'd9:  begin exc_code = 6'h08; exc_sub = 9'd1; exc_badv = wb_badv; end
            4'd10: begin exc_code = 6'h3F; exc_badv = wb_badv; end
            4'd11: begin exc_code = 6'h01; exc_badv = wb_badv; end
            4'd12: begin exc_code = 6'h02; exc_badv = wb_badv; end
            4'd13: begin exc_code = 6'h04; exc_badv = wb_badv; end
            default: exc_code = 6'h00;
        endcase
    end

    assign wb_ready     = (state == S_RUN);
    assign accept       = wb_ready & wb_valid;
    assign take_int     = accept & int_pend;
    assign take_exc     = accept & ~int_pend & exc_any;
    assign take_ertn    = accept & ~int_pend & ~exc_any & wb_is_ertn;
    assign take_refetch = accept & ~int_pend & ~exc_any & ~wb_is_ertn & wb_is_refetch;
    assign take_idle    = accept & ~int_pend & ~exc_any & ~wb_is_ertn & ~wb_is_refetch & wb_is_idle;
    assign idle_wake    = (state == S_IDLE) & int_pend;
    assign redirect     = take_int | take_exc | take_ertn | take_refetch;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_RUN;
            blank_cnt <= '0;
            int_pend  <= 1'b0;
            idle_pc   <= '0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= (state == S_BLANK) ? blank_cnt + 1'b1 : '0;
            int_pend  <= ie & (|(lie & is));
            if (take_idle) idle_pc <= wb_pc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (redirect)       state_nxt = S_BLANK;
                else if (take_idle) state_nxt = S_IDLE;
            end
            S_IDLE:  if (int_pend) state_nxt = S_BLANK;
            S_BLANK: if (blank_cnt == CNT_W'(BLANK_CYC - 1)) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // Data outputs are zero whenever their pulse is not firing.
    always_comb begin
        is_exc_d         = take_int | take_exc | idle_wake;
        is_ertn_d        = take_ertn;
        is_fetch_again_d = take_refetch;
        is_idle_d        = take_idle;
        excode_d         = take_exc ? exc_code : 6'h00;
        esubcode_d       = take_exc ? exc_sub  : 9'd0;
        badvaddr_d       = take_exc ? exc_badv : '0;
        csr_pc_d         = '0;
        if (take_int | take_exc | take_refetch | take_idle) csr_pc_d = wb_pc;
        else if (idle_wake)                                 csr_pc_d = idle_pc;
        flush_d          = (state != S_RUN) | redirect | take_idle;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            is_exc         <= 1'b0;
            excode         <= 6'h00;
            esubcode       <= 9'd0;
            badvaddr       <= '0;
            csr_pc         <= '0;
            is_ertn        <= 1'b0;
            is_fetch_again <= 1'b0;
            is_idle        <= 1'b0;
            flush          <= 1'b0;
        end else begin
            is_exc         <= is_exc_d;
            excode         <= excode_d;
            esubcode       <= esubcode_d;
            badvaddr       <= badvaddr_d;
            csr_pc         <= csr_pc_d;
            is_ertn        <= is_ertn_d;
            is_fetch_again <= is_fetch_again_d;
            is_idle        <= is_idle_d;
            flush          <= flush_d;
        end
    end

endmodule

// File: tb/tb_exc_commit.sv
// Bench for exc_commit: directed scenarios with literal expectations, then random traffic vs a cycle model.
module tb_exc_commit;
    localparam int PC_W = 32, INT_W = 12, BLANK_CYC = 1;
    localparam logic [5:0] CODE_TAB [14] = '{6'h08, 6'h3F, 6'h03, 6'h07, 6'h0B, 6'h0C, 6'h0D,
                                             6'h0E, 6'h09, 6'h08, 6'h3F, 6'h01, 6'h02, 6'h04};

    logic clk = 1'b0;
    logic reset;
    logic wb_valid, wb_ready, wb_is_ertn, wb_is_idle, wb_is_refetch, ie;
    logic [PC_W-1:0] wb_pc, wb_badv, badvaddr, csr_pc;
    logic [13:0] wb_exc_vec;
    logic [INT_W-1:0] lie, is;
    logic is_exc, is_ertn, is_fetch_again, is_idle, flush;
    logic [5:0] excode;
    logic [8:0] esubcode;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    exc_commit #(.PC_W(PC_W), .INT_W(INT_W), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
        .wb_exc_vec(wb_exc_vec), .wb_badv(wb_badv), .wb_is_ertn(wb_is_ertn), .wb_is_idle(wb_is_idle),
        .wb_is_refetch(wb_is_refetch), .ie(ie), .lie(lie), .is(is), .is_exc(is_exc), .excode(excode),
        .esubcode(esubcode), .badvaddr(badvaddr), .csr_pc(csr_pc), .is_ertn(is_ertn),
        .is_fetch_again(is_fetch_again), .is_idle(is_idle), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining-cycle counters for blanking/flush, a sleep flag for IDLE.
    bit m_pend, m_sleep, redirect;
    logic [PC_W-1:0] m_idle_pc;
    int m_blank_left, m_flush_left, k;
    bit e_exc, e_ertn, e_fa, e_idle, e_flush, e_ready;
    logic [5:0] e_excode;
    logic [8:0] e_esub;
    logic [PC_W-1:0] e_badv, e_pc;

    initial begin : model
        forever begin
            @(posedge clk);
            e_exc = 0; e_ertn = 0; e_fa = 0; e_idle = 0;
            e_excode = '0; e_esub = '0; e_badv = '0; e_pc = '0;
            if (!reset) begin
                m_pend = 0; m_sleep = 0; m_blank_left = 0; m_flush_left = 0;
                e_flush = 0; e_ready = 1;
            end else begin
                redirect = 0;
                if (m_sleep) begin
                    if (m_pend) begin
                        e_exc = 1; e_pc = m_idle_pc; m_sleep = 0; redirect = 1;
                    end
                end else if (m_blank_left > 0) begin
                    m_blank_left--;
                end else if (wb_valid) begin
                    if (m_pend) begin
                        e_exc = 1; e_pc = wb_pc; redirect = 1;
                    end else if (wb_exc_vec != 0) begin
                        k = 0;
                        while (!wb_exc_vec[k]) k++;
                        e_exc = 1; e_excode = CODE_TAB[k]; e_esub = (k == 9) ? 9'd1 : 9'd0;
                        e_badv = (k < 4) ? wb_pc : (k >= 8) ? wb_badv : '0;
                        e_pc = wb_pc; redirect = 1;
                    end else if (wb_is_ertn) begin
                        e_ertn = 1; redirect = 1;
                    end else if (wb_is_refetch) begin
                        e_fa = 1; e_pc = wb_pc; redirect = 1;
                    end else if (wb_is_idle) begin
                        e_idle = 1; e_pc = wb_pc; m_sleep = 1; m_idle_pc = wb_pc;
                    end
                end
                if (redirect) begin
                    m_blank_left = BLANK_CYC;
                    m_flush_left = BLANK_CYC + 1;
                end
                e_flush = (m_flush_left > 0) || m_sleep;
                if (m_flush_left > 0) m_flush_left--;
                e_ready = !m_sleep && (m_blank_left == 0);
                m_pend = ie && ((lie & is) != 0);
            end
            chk_en = 1'b1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("wb_ready", wb_ready, e_ready);
                check("is_exc", is_exc, e_exc);
                check("is_ertn", is_ertn, e_ertn);
                check("is_fetch_again", is_fetch_again, e_fa);
                check("is_idle", is_idle, e_idle);
                check("flush", flush, e_flush);
                if (e_exc) begin
                    check("excode", excode, e_excode);
                    check("esubcode", esubcode, e_esub);
                    check("badvaddr", badvaddr, e_badv);
                    check("csr_pc", csr_pc, e_pc);
                end else if (e_fa || e_idle) begin
                    check("csr_pc", csr_pc, e_pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        wb_valid = 0; wb_exc_vec = '0; wb_is_ertn = 0; wb_is_idle = 0; wb_is_refetch = 0;
    endtask

    task automatic clear_int();
        ie = 0; lie = '0; is = '0;
    endtask

    initial begin : stim
        reset = 0; wb_pc = '0; wb_badv = '0;
        clear_in(); clear_int();
        // T1: reset
        tick(); tick();
        check("t1_is_exc", is_exc, 0);
        check("t1_flush", flush, 0);
        check("t1_ready", wb_ready, 1);
        check("t1_csr_pc", csr_pc, 0);
        reset = 1;
        tick();
        check("t1_no_pulse", {is_exc, is_ertn, is_fetch_again, is_idle}, 0);
        // T2: INE
        wb_valid = 1; wb_pc = 32'h1c000010; wb_exc_vec = 14'h0040;
        tick(); clear_in();
        check("t2_is_exc", is_exc, 1);
        check("t2_excode", excode, 6'h0D);
        check("t2_csr_pc", csr_pc, 32'h1c000010);
        check("t2_flush0", flush, 1);
        check("t2_ready0", wb_ready, 0);
        tick();
        check("t2_flush1", flush, 1);
        check("t2_ready1", wb_ready, 1);
        check("t2_pulse_width", is_exc, 0);
        tick();
        check("t2_flush2", flush, 0);
        // T3: ALE beats ADEM and PIL
        wb_valid = 1; wb_pc = 32'h1c000020; wb_exc_vec = 14'h0B00; wb_badv = 32'h3;
        tick(); clear_in();
        check("t3_excode", excode, 6'h09);
        check("t3_esub", esubcode, 0);
        check("t3_badv", badvaddr, 32'h3);
        tick(); tick();
        // T4: interrupt outranks SYS
        ie = 1; lie = 12'h800; is = 12'h800;
        tick();
        wb_valid = 1; wb_pc = 32'h1c000030; wb_exc_vec = 14'h0010;
        tick(); clear_in(); clear_int();
        check("t4_is_exc", is_exc, 1);
        check("t4_excode", excode, 6'h00);
        check("t4_csr_pc", csr_pc, 32'h1c000030);
        tick(); tick();
        // T5: idle then wake on interrupt
        wb_valid = 1; wb_pc = 32'h1c000100; wb_is_idle = 1;
        tick(); clear_in();
        check("t5_is_idle", is_idle, 1);
        check("t5_ready", wb_ready, 0);
        check("t5_csr_pc", csr_pc, 32'h1c000100);
        repeat (20) tick();
        check("t5_still_idle", wb_ready, 0);
        ie = 1; lie = 12'h800; is = 12'h800;
        tick();
        check("t5_pend_lag", is_exc, 0);
        tick(); clear_int();
        check("t5_wake_exc", is_exc, 1);
        check("t5_wake_code", excode, 6'h00);
        check("t5_wake_pc", csr_pc, 32'h1c000100);
        tick();
        check("t5_run", wb_ready, 1);
        tick();
        // T6: ertn beats refetch; refetch alone; reset during blank
        wb_valid = 1; wb_pc = 32'h1c000200; wb_is_ertn = 1; wb_is_refetch = 1;
        tick(); clear_in();
        check("t6_ertn", is_ertn, 1);
        check("t6_no_fa", is_fetch_again, 0);
        tick(); tick();
        wb_valid = 1; wb_pc = 32'h1c000204; wb_is_refetch = 1;
        tick(); clear_in();
        check("t6_fa", is_fetch_again, 1);
        check("t6_fa_pc", csr_pc, 32'h1c000204);
        reset = 0;
        tick();
        check("t6_rst_flush", flush, 0);
        check("t6_rst_ready", wb_ready, 1);
        check("t6_rst_fa", is_fetch_again, 0);
        reset = 1;
        tick();
        // Random traffic
        repeat (4000) begin
            reset         = ($urandom_range(99) != 0);
            wb_valid      = ($urandom_range(1) == 1);
            wb_pc         = {$urandom} & 32'hFFFF_FFFC;
            wb_badv       = $urandom;
            wb_exc_vec    = ($urandom_range(3) == 0) ? 14'($urandom) : 14'h0;
            wb_is_ertn    = ($urandom_range(5) == 0);
            wb_is_idle    = ($urandom_range(5) == 0);
            wb_is_refetch = ($urandom_range(5) == 0);
            ie            = ($urandom_range(7) == 0);
            lie           = 12'($urandom);
            is            = 12'($urandom);
            tick();
        end
        reset = 1; clear_in(); clear_int();
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
